sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port SRAM (1024x32, 1-cycle registered read) among NUM_REQ requesters, e.g. the APB SRAM interface plus DMA/debug masters.
- Grants at most one access per cycle and drives the SRAM chip-select, write-enable, address and write-data directly.
- Returns read data one cycle after the grant, tagged to the owning requester.
- Sits between the requester bus interfaces and the spsram macro.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MEM_WIDTH, 32, data width
- MEM_BITW, 10, word-address width
- REQ_BITW, 1, log2 of NUM_REQ, used for pointer and tag width (set to at least 1)

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester access request
- req_we  in  NUM_REQ  per-requester write (1) / read (0)
- req_addr  in  NUM_REQ*MEM_BITW  flattened word addresses, requester i at slice i
- req_wdata  in  NUM_REQ*MEM_WIDTH  flattened write data
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- rsp_valid  out  NUM_REQ  one-hot read-data-valid, one cycle after a read grant
- rsp_rdata  out  MEM_WIDTH  read data shared by all requesters, qualified by rsp_valid
- mem_cs  out  1  SRAM chip select
- mem_we  out  1  SRAM write enable
- mem_addr  out  MEM_BITW  SRAM address
- mem_wdata  out  MEM_WIDTH  SRAM write data
- mem_rdata  in  MEM_WIDTH  SRAM dout, registered inside the SRAM

Behaviour:
- Reset is asynchronous, active-low, on clk/rstn as decided.
- Reset values: rr_ptr=0, rsp_valid=0, rsp_tag=0. req_ready and mem_cs are 0 because no request is valid in reset.
- Arbitration is combinational each cycle. Search starts at rr_ptr and proceeds upward modulo NUM_REQ. The first i with req_valid[i]=1 wins and gets req_ready[i]=1; all other ready bits are 0.
- No valid request: req_ready=0, mem_cs=0, mem_we=0. mem_addr and mem_wdata hold the last driven value; they must not toggle.
- On a grant to winner w:
  - mem_cs=1, mem_we=req_we[w], mem_addr=req_addr[w], mem_wdata=req_wdata[w], all in the same cycle.
  - rr_ptr updates to (w+1) mod NUM_REQ at the clock edge.
  - The pointer wraps from NUM_REQ-1 to 0.
- Read latency is exactly 1 cycle:
  - A registered pending bit and tag record the read grant.
  - In the next cycle, rsp_valid[tag]=1 and rsp_rdata=mem_rdata (pass-through of the SRAM registered output).
- Write grants produce no rsp_valid. A write completes at the granting edge.
- Back-to-back grants:
  - A new grant (read or write) is allowed in the same cycle as an earlier read's rsp_valid.
  - Full throughput is 1 access per cycle.
- A requester may keep req_valid high after being served. Round-robin then serves other valid requesters before it returns. With N requesters continuously valid, each is granted once every N cycles.
- Requester contract: req_valid, once high, holds with stable address, data and we until ready. The arbiter does not check this.
- Reset mid-operation: a pending read's rsp_valid is suppressed, and any in-flight write is whatever the SRAM captured at the last edge.
- Single requester active: it is granted every cycle regardless of rr_ptr.

Optional Feature:
- Macro: SRAM_ARB_PRIO0_EN.
- Defined: requester 0 has absolute priority. Whenever req_valid[0]=1 it wins, and rr_ptr is not updated on that grant. The remaining requesters share the other cycles round-robin.
- Undefined: pure round-robin over all requesters as above.

Decomposition:
- Package sram_arb_pkg holds:
  - default MEM_WIDTH/MEM_BITW constants
  - a function for the rotate-and-find-first one-hot grant
  - a function for one-hot-to-index encoding
- Sub-module rr_pick:
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, winner index and any-valid flag.
  - Purely combinational, reused by other shared-resource arbiters.
- The top level holds rr_ptr, the response pipeline and the SRAM mux.

Test Plan:
- Single write then read, with spsram instanced: req0 writes addr 0x3FC data 0xFFFF_FF01 → req_ready[0]=1 that cycle. req0 then reads addr 0x3FC → rsp_valid[0]=1 one cycle later with rsp_rdata=0xFFFF_FF01.
- Contention: req0 and req1 both read continuously from rr_ptr=0 → grants alternate 0,1,0,1. rsp_valid follows one cycle behind each grant with matching tag and data.
- Pointer wrap, NUM_REQ=4: all four valid → grants 0,1,2,3,0. Only req3 then req1 valid → grant 3, then 1.
- Mixed traffic: req1 writes addr 5 data 0xA5A5_A5A5 while req0 reads addr 5 on the following grant → read returns 0xA5A5_A5A5. No rsp_valid appears for the write.
- Reset mid-read: assert rstn=0 in the cycle after a read grant → rsp_valid=0 immediately, rr_ptr=0. The first grant after release goes to the lowest valid index.
- SRAM_ARB_PRIO0_EN defined: req0 held valid for 3 cycles with req1 valid → req0 granted 3 times, then req1 in cycle 4. Undefined: alternating grants.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared constants and grant-selection helpers for the SRAM arbiter and other
// round-robin arbiters over shared resources.
package sram_arb_pkg;

  localparam int unsigned MEM_WIDTH_DEF = 32;
  localparam int unsigned MEM_BITW_DEF  = 10;
  localparam int unsigned MAX_REQ       = 8;

  // Starting at ptr and moving upward modulo n, one-hot of the first set bit in req.
  function automatic logic [MAX_REQ-1:0] rr_first_onehot(logic [MAX_REQ-1:0] req,
                                                         int unsigned ptr,
                                                         int unsigned n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int unsigned        idx;
    gnt   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

  function automatic int unsigned onehot_to_idx(logic [MAX_REQ-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (oh[k[2:0]]) idx = idx | k;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant, winner index and any-valid
// flag for a request vector searched upward from a pointer.
module rr_pick
  import sram_arb_pkg::*;
#(
  parameter int unsigned N     = 2,
  parameter int unsigned PTR_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [MAX_REQ-1:0] req_pad;
  logic [MAX_REQ-1:0] gnt_pad;

  always_comb begin
    req_pad        = '0;
    req_pad[N-1:0] = req;
    gnt_pad        = rr_first_onehot(req_pad, 32'(ptr), N);
    gnt            = gnt_pad[N-1:0];
    idx            = PTR_W'(onehot_to_idx(gnt_pad));
    any            = |req;
  end

endmodule

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port SRAM among NUM_REQ requesters.
// Optional SRAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module sram_rr_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned MEM_WIDTH = MEM_WIDTH_DEF,
  parameter int unsigned MEM_BITW  = MEM_BITW_DEF,
  parameter int unsigned REQ_BITW  = 1
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*MEM_BITW-1:0]    req_addr,
  input  logic [NUM_REQ*MEM_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic [MEM_WIDTH-1:0]           rsp_rdata,
  output logic                           mem_cs,
  output logic                           mem_we,
  output logic [MEM_BITW-1:0]            mem_addr,
  output logic [MEM_WIDTH-1:0]           mem_wdata,
  input  logic [MEM_WIDTH-1:0]           mem_rdata
);

  logic [REQ_BITW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [REQ_BITW-1:0]  win_idx;
  logic [REQ_BITW-1:0]  tag_q;
  logic                 pend_q;
  logic [NUM_REQ-1:0]   gnt;
  logic                 any;
  logic                 adv_ptr;
  logic [MEM_BITW-1:0]  addr_q;
  logic [MEM_WIDTH-1:0] wdata_q;

`ifdef SRAM_ARB_PRIO0_EN
  logic [NUM_REQ-1:0]  rr_req;
  logic [NUM_REQ-1:0]  rr_gnt;
  logic [REQ_BITW-1:0] rr_idx;
  logic                rr_any;

  always_comb begin
    rr_req    = req_valid;
    rr_req[0] = 1'b0;
  end

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (REQ_BITW)
  ) u_pick (
    .req (rr_req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  // Requester 0 bypasses the rotation and leaves the pointer where it was.
  always_comb begin
    gnt     = rr_gnt;
    win_idx = rr_idx;
    any     = rr_any;
    adv_ptr = rr_any;
    if (req_valid[0]) begin
      gnt     = '0;
      gnt[0]  = 1'b1;
      win_idx = '0;
      any     = 1'b1;
      adv_ptr = 1'b0;
    end
  end
`else
  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (REQ_BITW)
  ) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .gnt (gnt),
    .idx (win_idx),
    .any (any)
  );

  assign adv_ptr = any;
`endif

  // Address and data hold their last granted value when idle to avoid toggling.
  always_comb begin
    req_ready = gnt;
    mem_cs    = any;
    mem_we    = any & req_we[win_idx];
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    if (any) begin
      mem_addr  = req_addr[win_idx*MEM_BITW +: MEM_BITW];
      mem_wdata = req_wdata[win_idx*MEM_WIDTH +: MEM_WIDTH];
    end
    rr_ptr_d = rr_ptr_q;
    if (adv_ptr) begin
      rr_ptr_d = (win_idx == REQ_BITW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    rsp_valid = '0;
    if (pend_q) rsp_valid[tag_q] = 1'b1;
    rsp_rdata = mem_rdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      pend_q   <= 1'b0;
      tag_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      pend_q   <= any & ~mem_we;
      if (any & ~mem_we) tag_q <= win_idx;
      if (any) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Self-checking bench for sram_rr_arbiter (NUM_REQ=4) with a behavioural SRAM and
// reference model; honours SRAM_ARB_PRIO0_EN in its model.
module tb_sram_rr_arbiter;

  localparam int N  = 4;
  localparam int RB = 2;
  localparam int DW = 32;
  localparam int AW = 10;

  logic          clk  = 1'b0;
  logic          rstn = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_we    = '0;
  logic [N*AW-1:0] req_addr  = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    req_ready, rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_cs, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  sram_rr_arbiter #(
    .NUM_REQ   (N),
    .MEM_WIDTH (DW),
    .MEM_BITW  (AW),
    .REQ_BITW  (RB)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Single-port SRAM, 1024x32, registered read.
  logic [DW-1:0] sram [1024];
  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) sram[mem_addr] <= mem_wdata;
      else        mem_rdata      <= sram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [DW-1:0] ref_mem [1024];
  int            m_ptr;
  bit            m_pend;
  int            m_tag;
  logic [DW-1:0] m_exp_rdata;
  bit            addr_known;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wdata;
  int            last_win;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  function automatic int model_winner();
`ifdef SRAM_ARB_PRIO0_EN
    if (req_valid[0]) return 0;
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (i != 0 && req_valid[i]) return i;
    end
`else
    for (int k = 0; k < N; k++) begin
      int i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
`endif
    return -1;
  endfunction

  // Check one cycle's outputs at the negedge, then advance the model past the posedge.
  task automatic step();
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    w = model_winner();
    chk("req_ready", 64'(req_ready), (w >= 0) ? 64'(1 << w) : 64'd0);
    chk("mem_cs", 64'(mem_cs), (w >= 0) ? 64'd1 : 64'd0);
    if (w >= 0) begin
      chk("mem_we", 64'(mem_we), 64'(req_we[w]));
      chk("mem_addr", 64'(mem_addr), 64'(req_addr[w*AW +: AW]));
      chk("mem_wdata", 64'(mem_wdata), 64'(req_wdata[w*DW +: DW]));
    end else begin
      chk("mem_we_idle", 64'(mem_we), 64'd0);
      if (addr_known) begin
        chk("mem_addr_hold", 64'(mem_addr), 64'(m_last_addr));
        chk("mem_wdata_hold", 64'(mem_wdata), 64'(m_last_wdata));
      end
    end
    chk("rsp_valid", 64'(rsp_valid), m_pend ? 64'(1 << m_tag) : 64'd0);
    if (m_pend) chk("rsp_rdata", 64'(rsp_rdata), 64'(m_exp_rdata));
    last_win = w;
    m_pend   = 1'b0;
    if (w >= 0) begin
      a = req_addr[w*AW +: AW];
      d = req_wdata[w*DW +: DW];
      if (req_we[w]) ref_mem[a] = d;
      else begin
        m_pend      = 1'b1;
        m_tag       = w;
        m_exp_rdata = ref_mem[a];
      end
      m_last_addr  = a;
      m_last_wdata = d;
      addr_known   = 1'b1;
`ifdef SRAM_ARB_PRIO0_EN
      if (w != 0) m_ptr = (w + 1) % N;
`else
      m_ptr = (w + 1) % N;
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rstn      = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_mem_cs", 64'(mem_cs), 64'd0);
    m_ptr      = 0;
    m_pend     = 1'b0;
    addr_known = 1'b0;
    last_win   = -1;
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_c[4];
    int exp_w[5];
    int exp_p[4];
    for (int i = 0; i < 1024; i++) begin
      sram[i]    = '0;
      ref_mem[i] = '0;
    end
    m_ptr    = 0;
    last_win = -1;
    do_reset();

    // Write then read back at the top of the address space.
    set_req(0, 1'b1, 10'h3FC, 32'hFFFF_FF01);
    step();
    chk("wr_grant", 64'(last_win), 64'd0);
    req_valid = '0;
    set_req(0, 1'b0, 10'h3FC, 32'h0);
    step();
    req_valid = '0;
    chk("rd_rsp_valid_lit", 64'(rsp_valid), 64'h1);
    chk("rd_rsp_data_lit", 64'(rsp_rdata), 64'hFFFF_FF01);
    step();

    // Two readers contending from rr_ptr=0.
    do_reset();
`ifdef SRAM_ARB_PRIO0_EN
    exp_c = '{0, 0, 0, 0};
`else
    exp_c = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b0, 10'h3FC, 32'h0);
    set_req(1, 1'b0, 10'h005, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("contention_seq", 64'(last_win), 64'(exp_c[k]));
    end
    req_valid = '0;
    step();

    // Pointer wrap with all four valid, then only req1/req3.
    do_reset();
`ifdef SRAM_ARB_PRIO0_EN
    exp_w = '{0, 0, 0, 0, 0};
`else
    exp_w = '{0, 1, 2, 3, 0};
`endif
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 10'(i + 16), 32'h0);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("wrap_seq", 64'(last_win), 64'(exp_w[k]));
    end
    req_valid = '0;
    set_req(1, 1'b0, 10'h011, 32'h0);
    step();
    chk("wrap_req1_alone", 64'(last_win), 64'd1);
    set_req(3, 1'b0, 10'h013, 32'h0);
    step();
    chk("wrap_pick3", 64'(last_win), 64'd3);
    req_valid[3] = 1'b0;
    step();
    chk("wrap_pick1", 64'(last_win), 64'd1);
    req_valid = '0;

    // Write from req1 then read of the same word by req0.
    set_req(1, 1'b1, 10'h005, 32'hA5A5_A5A5);
    step();
    req_valid = '0;
    chk("mixed_no_wr_rsp", 64'(rsp_valid), 64'd0);
    set_req(0, 1'b0, 10'h005, 32'h0);
    step();
    req_valid = '0;
    chk("mixed_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("mixed_rdata", 64'(rsp_rdata), 64'hA5A5_A5A5);

    // Reset in the cycle after a read grant.
    set_req(2, 1'b0, 10'h005, 32'h0);
    step();
    chk("midrd_rsp_before", 64'(rsp_valid), 64'h4);
    do_reset();
    set_req(2, 1'b0, 10'h005, 32'h0);
    set_req(3, 1'b0, 10'h3FC, 32'h0);
    step();
    chk("post_rst_lowest", 64'(last_win), 64'd2);
    req_valid = '0;
    step();

    // req0 held for three grants alongside req1.
    do_reset();
`ifdef SRAM_ARB_PRIO0_EN
    exp_p = '{0, 0, 0, 1};
`else
    exp_p = '{0, 1, 0, 1};
`endif
    set_req(0, 1'b0, 10'h3FC, 32'h0);
    set_req(1, 1'b0, 10'h005, 32'h0);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) req_valid[0] = 1'b0;
      step();
      chk("prio_seq", 64'(last_win), 64'(exp_p[k]));
    end
    req_valid = '0;
    step();

    // Randomized traffic against the model, small address range for collisions.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && last_win == i && $urandom_range(3) != 0) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(1) == 1)
          set_req(i, 1'($urandom_range(1)), 10'($urandom_range(15)), $urandom);
      end
      if (c == 1500) do_reset();
      step();
    end
    req_valid = '0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
